spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk, mosi and cs_n.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning RX FIFO entries (power of 2).
REQ-003 SHALL have port clk, input, 1, system clock; the block has one clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port sel, input, 1, register-bus select.
REQ-006 SHALL have port w_en, input, 1, register write strobe (qualified by sel).
REQ-007 SHALL have port r_en, input, 1, register read strobe (qualified by sel).
REQ-008 SHALL have port wdata, input, 32, write data.
REQ-009 SHALL have port rdata, output, 32, read data.
REQ-010 SHALL have port offset, input, 2, register select: 00 CNTRL, 01 TXDATA, 10 RXDATA, 11 STATUS.
REQ-011 SHALL have port sclk, input, 1, SPI clock from the master.
REQ-012 SHALL have port mosi, input, 1, serial data from the master.
REQ-013 SHALL have port cs_n, input, 1, active-low frame select.
REQ-014 SHALL have port miso, output, 1, serial data to the master.
REQ-015 SHALL have port irq, output, 1, level interrupt.

Function
REQ-016 SHALL pass sclk, mosi and cs_n through SYNC_STAGES flops and detect edges by comparing each synchronized value with its previous value.
REQ-017 SHALL operate in SPI mode 0, MSB first, 8-bit bytes: mosi sampled on synchronized sclk rise, miso updated on synchronized sclk fall.
REQ-018 SHALL require sclk high and low phases of at least 4 clk cycles each; behaviour is undefined below this.
REQ-019 SHALL use FSM states IDLE and ACTIVE.
REQ-020 IDLE -> ACTIVE on a synchronized cs_n fall with en=1: bit_cnt=0, shift_tx loaded per REQ-024, miso=shift_tx[7].
REQ-021 ACTIVE, sclk rise: shift_rx={shift_rx[6:0],mosi}, bit_cnt++ (3-bit, wraps 7->0); on the wrap, push the completed byte to the RX FIFO.
REQ-022 ACTIVE, sclk fall: if bit_cnt==0, reload shift_tx per REQ-024 and drive its bit 7; otherwise shift shift_tx left and drive the new bit 7.
REQ-023 ACTIVE -> IDLE on synchronized cs_n rise or en=0; if bit_cnt!=0, discard the partial byte and set frame_err; miso=0 in IDLE.
REQ-024 Byte load: if tx_full=1, load tx_hold and clear tx_full; else load 0xFF and set tx_underrun.
REQ-025 A TXDATA write in the same cycle as a byte load: load uses the old tx_hold, then tx_hold=new value and tx_full=1.
REQ-026 A TXDATA write SHALL set tx_hold=wdata[7:0] and tx_full=1, overwriting any unconsumed value.
REQ-027 RX push when full and no same-cycle pop: drop the byte, set overrun, FIFO unchanged.
REQ-028 RX push and pop in the same cycle when full: both occur, count unchanged, no overrun.
REQ-029 A cycle with sel&&r_en at RXDATA SHALL pop one entry if non-empty; an empty pop SHALL be ignored.
REQ-030 rdata SHALL be combinational: CNTRL={30'd0,irq_en,en}; TXDATA={23'd0,tx_full,tx_hold}; RXDATA={24'd0,FIFO head, or 0 if empty}.
REQ-031 STATUS rdata SHALL be {21'd0,rx_count[2:0],2'd0,frame_err,tx_underrun,overrun,rx_full,rx_avail,busy}; busy=(state==ACTIVE); rdata=0 when !(sel&&r_en).
REQ-032 A CNTRL write SHALL set en=wdata[0] and irq_en=wdata[1].
REQ-033 A STATUS write SHALL clear overrun, tx_underrun and frame_err for each wdata bit 3, 4, 5 that is 1 (W1C); a same-cycle set SHALL win.
REQ-034 irq SHALL be registered and equal irq_en & (rx_avail | overrun | frame_err).

Reset
REQ-035 On rst=1 at a clk edge: state=IDLE, miso=0, irq=0, en=0, irq_en=0, tx_hold=0, tx_full=0, FIFO empty, all sticky flags=0, shift registers and bit_cnt=0, synchronizers=idle levels (sclk 0, cs_n 1).
REQ-036 Reset mid-frame SHALL abort without pushing; the block stays IDLE until the next cs_n fall after reset is released.

Verification
REQ-037 en=1, TXDATA=0xA5; master sends 0x3C at 8 clk per sclk phase -> miso bits 10100101, RXDATA=0x3C, rx_count 1->0 after the read.
REQ-038 Five bytes with no reads (FIFO_DEPTH=4) -> first four stored in order, overrun=1, 5th dropped; STATUS write 0x08 clears overrun.
REQ-039 Frame with no TXDATA write -> miso sends 0xFF, tx_underrun=1.
REQ-040 cs_n rises after 5 bits -> frame_err=1, rx_count unchanged, irq=1 if irq_en=1.
REQ-041 Pop RXDATA in the same cycle a push arrives with the FIFO full -> overrun stays 0, rx_count stays 4.
REQ-042 rst asserted mid-byte -> all outputs at reset values the next cycle; the following full frame is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : SPI mode-0 slave (MSB first, 8-bit) with a 32-bit register bus,
//            single-byte TX holding register and an RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        w_en,
    input  logic        r_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso,
    output logic        irq
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_off_cntrl  = 2'b00;
    localparam logic [1:0] c_off_txdata = 2'b01;
    localparam logic [1:0] c_off_rxdata = 2'b10;
    localparam logic [1:0] c_off_status = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift_rx;
    logic [7:0]  r_shift_tx;
    logic        r_miso;
    logic [7:0]  r_tx_hold;
    logic        r_tx_full;
    logic        r_enable;
    logic        r_irq_en;
    logic        r_overrun;
    logic        r_underrun;
    logic        r_frame_err;
    logic        r_irq;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic w_sclk_s, w_mosi_s, w_cs_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_load, w_shift, w_sample, w_abort;
    logic w_push_req, w_push, w_pop, w_drop;
    logic w_fifo_full, w_rx_avail;
    logic w_wr_cntrl, w_wr_tx, w_wr_status, w_rd;
    logic [7:0] w_load_byte;
    logic [7:0] w_rx_byte;
    logic [7:0] w_head;
    logic [2:0] w_count3;
    logic       w_unused;

    // Idle levels are sclk low and cs_n high so reset never fakes an edge.
    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sclk_sync <= '0;
                    r_mosi_sync <= '0;
                    r_cs_sync   <= '1;
                end else begin
                    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
                    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
                    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
                end
            end
        end else begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sclk_sync <= '0;
                    r_mosi_sync <= '0;
                    r_cs_sync   <= '1;
                end else begin
                    r_sclk_sync <= sclk;
                    r_mosi_sync <= mosi;
                    r_cs_sync   <= cs_n;
                end
            end
        end
    endgenerate

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_sample     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_enable) begin
                    w_state_next = ACTIVE;
                    w_load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise || !r_enable) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_sample = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_load  = (r_bit_cnt == 3'd0);
                        w_shift = (r_bit_cnt != 3'd0);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_wr_cntrl  = sel && w_en && (offset == c_off_cntrl);
    assign w_wr_tx     = sel && w_en && (offset == c_off_txdata);
    assign w_wr_status = sel && w_en && (offset == c_off_status);
    assign w_rd        = sel && r_en;

    assign w_load_byte = r_tx_full ? r_tx_hold : 8'hFF;
    assign w_rx_byte   = {r_shift_rx[6:0], w_mosi_s};

    assign w_fifo_full = (r_count == c_full_count);
    assign w_rx_avail  = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count3    = 3'(r_count);

    // A pop in the same cycle frees the slot the push needs.
    assign w_push_req = w_sample && (r_bit_cnt == 3'd7);
    assign w_pop      = w_rd && (offset == c_off_rxdata) && w_rx_avail;
    assign w_push     = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop     = w_push_req && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift_rx <= 8'h00;
            r_shift_tx <= 8'h00;
            r_miso     <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift_tx <= w_load_byte;
                r_miso     <= w_load_byte[7];
            end else if (w_shift) begin
                r_shift_tx <= {r_shift_tx[6:0], 1'b0};
                r_miso     <= r_shift_tx[6];
            end else if (w_abort) begin
                r_miso <= 1'b0;
            end
            if (w_sample) begin
                r_shift_rx <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_abort) begin
                r_shift_rx <= 8'h00;
                r_bit_cnt  <= 3'd0;
            end
        end
    end

    // The load consumes the old holding byte before a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_hold <= 8'h00;
            r_tx_full <= 1'b0;
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            if (w_load && r_tx_full) r_tx_full <= 1'b0;
            if (w_wr_tx) begin
                r_tx_hold <= wdata[7:0];
                r_tx_full <= 1'b1;
            end
            if (w_wr_cntrl) begin
                r_enable <= wdata[0];
                r_irq_en <= wdata[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr_status && wdata[3]) r_overrun   <= 1'b0;
            if (w_wr_status && wdata[4]) r_underrun  <= 1'b0;
            if (w_wr_status && wdata[5]) r_frame_err <= 1'b0;
            if (w_drop)                  r_overrun   <= 1'b1;
            if (w_load && !r_tx_full)    r_underrun  <= 1'b1;
            if (w_abort && (r_bit_cnt != 3'd0)) r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= r_irq_en & (w_rx_avail | r_overrun | r_frame_err);
    end

    always_comb begin
        rdata = 32'd0;
        if (w_rd) begin
            case (offset)
                c_off_cntrl:  rdata = {30'd0, r_irq_en, r_enable};
                c_off_txdata: rdata = {23'd0, r_tx_full, r_tx_hold};
                c_off_rxdata: rdata = {24'd0, (w_rx_avail ? w_head : 8'h00)};
                c_off_status: rdata = {21'd0, w_count3, 2'd0, r_frame_err, r_underrun,
                                       r_overrun, w_fifo_full, w_rx_avail,
                                       (r_state == ACTIVE)};
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign miso     = r_miso;
    assign irq      = r_irq;
    assign w_unused = &{1'b0, wdata[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Randomized self-checking bench for spi_slave with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst, sel, w_en, r_en, sclk, mosi, cs_n;
    logic [31:0] wdata, rdata;
    logic [1:0]  offset;
    logic        miso, irq;

    spi_slave #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .w_en(w_en), .r_en(r_en),
        .wdata(wdata), .rdata(rdata), .offset(offset),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_en, m_irq_en, m_full, m_ov, m_ur, m_fe;
    logic [7:0] m_hold;
    logic [7:0] popped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0; m_irq_en = 0; m_full = 0; m_ov = 0; m_ur = 0; m_fe = 0;
        m_hold = 8'h00;
    endtask

    task automatic model_load(output logic [7:0] b);
        if (m_full) begin
            b = m_hold;
            m_full = 1'b0;
        end else begin
            b = 8'hFF;
            m_ur = 1'b1;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() >= 4) m_ov = 1'b1;
        else               q.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] o, input logic [31:0] d);
        @(negedge clk);
        sel = 1; w_en = 1; offset = o; wdata = d;
        @(negedge clk);
        sel = 0; w_en = 0; wdata = 0;
    endtask

    task automatic bus_read(input logic [1:0] o, output logic [31:0] d);
        @(negedge clk);
        sel = 1; r_en = 1; offset = o;
        #1 d = rdata;
        @(negedge clk);
        sel = 0; r_en = 0;
    endtask

    task automatic write_ctl(input logic [31:0] v);
        bus_write(2'b00, v);
        m_en = v[0]; m_irq_en = v[1];
    endtask

    task automatic write_tx(input logic [7:0] v);
        bus_write(2'b01, {24'd0, v});
        m_hold = v; m_full = 1'b1;
    endtask

    task automatic write_stat(input logic [31:0] v);
        bus_write(2'b11, v);
        if (v[3]) m_ov = 1'b0;
        if (v[4]) m_ur = 1'b0;
        if (v[5]) m_fe = 1'b0;
    endtask

    task automatic read_rx();
        logic [31:0] d;
        logic [7:0]  e;
        e = (q.size() != 0) ? q[0] : 8'h00;
        bus_read(2'b10, d);
        check("rxdata", d, {24'd0, e});
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic check_state(input string tag);
        logic [31:0] d;
        logic [31:0] st;
        st = {21'd0, 3'(q.size()), 2'd0, m_fe, m_ur, m_ov,
              (q.size() == 4), (q.size() != 0), 1'b0};
        idle(2);
        check({tag, ".irq"}, {31'd0, irq},
              {31'd0, m_irq_en & ((q.size() != 0) | m_ov | m_fe)});
        bus_read(2'b11, d);
        check({tag, ".status"}, d, st);
        bus_read(2'b00, d);
        check({tag, ".cntrl"}, d, {30'd0, m_irq_en, m_en});
        bus_read(2'b01, d);
        check({tag, ".txdata"}, d, {23'd0, m_full, m_hold});
    endtask

    // Master side: 8 clk per sclk phase; miso sampled just before each rise.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit pop_last,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            idle(8);
            got[i] = miso;
            sclk = 1'b1;
            if (pop_last && i == 0) begin
                // Synchronizer plus edge compare puts the push two cycles out.
                idle(2);
                sel = 1; r_en = 1; offset = 2'b10;
                #1 popped = rdata[7:0];
                idle(1);
                sel = 0; r_en = 0;
                idle(5);
            end else begin
                idle(8);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int nbytes, input int tail, input bit pop_last,
                         input bit use_fixed, input logic [7:0] fixed);
        logic [7:0] cur, b, got, e;
        bit         pop_now;
        int         sh;
        cs_n = 1'b0;
        model_load(cur);
        for (int k = 0; k < nbytes; k++) begin
            b = use_fixed ? fixed : 8'($urandom);
            pop_now = pop_last && (k == nbytes - 1);
            spi_bits(b, 8, pop_now, got);
            check("miso_byte", {24'd0, got}, {24'd0, cur});
            if (pop_now) begin
                e = (q.size() != 0) ? q[0] : 8'h00;
                check("pop_with_push", {24'd0, popped}, {24'd0, e});
                if (q.size() != 0) void'(q.pop_front());
            end
            model_push(b);
            model_load(cur);
        end
        if (tail > 0) begin
            b = 8'($urandom);
            spi_bits(b, tail, 1'b0, got);
            sh = 8 - tail;
            check("miso_tail", {24'd0, got >> sh}, {24'd0, cur >> sh});
            m_fe = 1'b1;
        end
        idle(8);
        cs_n = 1'b1;
        idle(8);
    endtask

    initial begin
        logic [7:0] junk;
        int nb, tl, nr;
        rst = 1; sel = 0; w_en = 0; r_en = 0; wdata = 0; offset = 0;
        sclk = 0; mosi = 0; cs_n = 1; popped = 0;
        model_reset();
        idle(3);
        #1;
        check("reset.miso", {31'd0, miso}, 32'd0);
        check("reset.irq", {31'd0, irq}, 32'd0);
        rst = 0;
        check_state("reset");

        // Directed: TX 0xA5 while master sends 0x3C.
        write_ctl(32'd1);
        write_tx(8'hA5);
        frame(1, 0, 1'b0, 1'b1, 8'h3C);
        check_state("a5_3c");
        read_rx();
        check_state("a5_3c_read");

        // Frame with no TX write sends 0xFF and flags underrun.
        write_stat(32'h38);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        check_state("underrun");
        read_rx();

        // Five bytes into a four-deep FIFO.
        frame(5, 0, 1'b0, 1'b0, 8'h00);
        check_state("overrun");
        write_stat(32'h08);
        check_state("overrun_clr");
        repeat (4) read_rx();
        check_state("drained");

        // Pop coinciding with a push into a full FIFO.
        frame(4, 0, 1'b0, 1'b0, 8'h00);
        frame(1, 0, 1'b1, 1'b0, 8'h00);
        check_state("full_pop_push");
        repeat (4) read_rx();

        // Partial byte aborts the frame.
        write_ctl(32'd3);
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        frame(0, 5, 1'b0, 1'b0, 8'h00);
        check_state("frame_err");
        read_rx();
        write_stat(32'h38);
        check_state("flags_clr");

        // Reset in the middle of a byte.
        frame(1, 0, 1'b0, 1'b0, 8'h00);
        write_tx(8'($urandom));
        cs_n = 1'b0;
        spi_bits(8'($urandom), 3, 1'b0, junk);
        idle(2);
        rst = 1;
        idle(1);
        #1;
        check("midrst.miso", {31'd0, miso}, 32'd0);
        check("midrst.irq", {31'd0, irq}, 32'd0);
        rst = 0;
        cs_n = 1'b1;
        model_reset();
        check_state("midrst");
        write_ctl(32'd1);
        write_tx(8'($urandom));
        frame(2, 0, 1'b0, 1'b0, 8'h00);
        check_state("after_rst");
        repeat (2) read_rx();

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            write_ctl({30'd0, 1'($urandom_range(0, 1)), 1'b1});
            nb = $urandom_range(0, 3);
            tl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (nb == 0 && tl == 0) nb = 1;
            frame(nb, tl, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            check_state("rand_frame");
            nr = $urandom_range(0, 3);
            repeat (nr) read_rx();
            if ($urandom_range(0, 1) == 1)
                write_stat({26'd0, 3'($urandom_range(0, 7)), 3'd0});
            check_state("rand_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
